// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin output arbiter.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ            = 4;
    localparam int unsigned SEL_W              = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t StIdle  = 2'd0;
    localparam arb_state_t StGrant = 2'd1;
    localparam arb_state_t StGap   = 2'd2;

    // First set request at or after last+1, wrapping; returns last when none is set.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        logic             found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mux41.sv
// Plain 4:1 single-bit multiplexer.
module mux41 (
    input  logic [1:0] sel_i,
    input  logic [3:0] d_i,
    output logic       y_o
);

    always_comb begin
        y_o = d_i[sel_i];
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin owner of a shared output bit, no preemption, one GAP cycle per
// release. Define ARB_TIMEOUT_EN to bound grant length and mask timed-out requesters.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic               D1,
    input  logic               D2,
    input  logic               D3,
    input  logic               D4,
    output logic [NUM_REQ-1:0] GNT,
    output logic [SEL_W-1:0]   S,
    output logic               BUSY,
    output logic               Y
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..31");
    end

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] req_elig;
    logic [SEL_W-1:0]   win;
    logic               owner_req;
    logic               mux_y;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 5;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;

    assign req_elig = REQ & ~mask_q;
`else
    assign req_elig = REQ;
`endif

    assign win       = rr_pick(req_elig, last_q);
    assign owner_req = REQ[sel_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        // A mask bit survives only while its requester keeps REQ high.
        mask_d  = mask_q & REQ;
`endif
        case (state_q)
            StIdle: begin
                if (|req_elig) begin
                    state_d = StGrant;
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    sel_d   = win;
                    last_d  = win;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StGrant: begin
                if (!owner_req) begin
                    state_d = StGap;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = StGap;
                    gnt_d         = '0;
                    busy_d        = 1'b0;
                    mask_d[sel_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
            busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
`endif
        end
    end

    mux41 u_mux41 (
        .sel_i (sel_q),
        .d_i   ({D4, D3, D2, D1}),
        .y_o   (mux_y)
    );

    assign GNT  = gnt_q;
    assign S    = sel_q;
    assign BUSY = busy_q;
    assign Y    = mux_y & busy_q;

endmodule
